// File: rtl/mem_stage_ctrl.sv
// -----------------------------------------------------------------------------
// mem_stage_ctrl
//
// MEM-stage controller sitting behind the EX/MEM pipeline latch. It launches a
// registered req/ack data-memory access for loads and stores, stalls the
// upstream pipeline while the access is outstanding, and loads the MEM/WB
// register when the stage retires (immediately for non-memory ops, on ack for
// memory ops).
//
// Optional feature macro: MEM_TIMEOUT_EN
//   Defined   -> a BUSY-cycle counter aborts an access that sees no ack within
//                TIMEOUT BUSY cycles and raises the sticky mem_err flag.
//   Undefined -> BUSY waits indefinitely for ack; mem_err is tied to 0.
//
// Ports:
//   clk, rst                    clock (rising edge), synchronous active-high reset
//   mem_write_reg/mem_read_reg  latched store / load enables (store wins if both)
//   reg_write_reg               latched writeback enable
//   alu_result_reg              latched ALU result, also the memory address
//   write_data_reg              latched store data
//   rd_reg                      latched destination register
//   dmem_req/we/addr/wdata      registered memory request
//   dmem_rdata, dmem_ack        memory read data and one-cycle completion
//   stall                       combinational freeze of EX/MEM and earlier stages
//   wb_*                        MEM/WB register fields
//   mem_err                     sticky access-timeout flag
// -----------------------------------------------------------------------------
module mem_stage_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int REG_W   = 5,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_write_reg,
    input  logic              mem_read_reg,
    input  logic              reg_write_reg,
    input  logic [ADDR_W-1:0] alu_result_reg,
    input  logic [DATA_W-1:0] write_data_reg,
    input  logic [REG_W-1:0]  rd_reg,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic              stall,
    output logic              wb_reg_write,
    output logic              wb_mem_to_reg,
    output logic [REG_W-1:0]  wb_rd,
    output logic [DATA_W-1:0] wb_read_data,
    output logic [ADDR_W-1:0] wb_alu_result,
    output logic              mem_err
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0] state;
    logic       access;
    logic       busy;
    logic       abort;

    assign access = mem_write_reg | mem_read_reg;
    assign busy   = (state == BUSY);

    // An abort point at count TIMEOUT-1 only makes sense for TIMEOUT >= 2.
    if (TIMEOUT < 2) begin : g_timeout_below_two
    end

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] busy_cnt;

    // Abort in the TIMEOUT-th BUSY cycle without ack; an ack in that cycle wins.
    assign abort = busy & ~dmem_ack & (busy_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_cnt <= '0;
            mem_err  <= 1'b0;
        end else begin
            if (!busy)
                busy_cnt <= '0;
            else if (!dmem_ack)
                busy_cnt <= busy_cnt + 1'b1;
            if (abort)
                mem_err <= 1'b1;
        end
    end
`else
    assign abort   = 1'b0;
    assign mem_err = 1'b0;
`endif

    // Stall while a new access is detected in IDLE or an access is still
    // outstanding; the retire cycle (ack or abort) releases the pipeline so the
    // EX/MEM latch advances on the same edge that loads MEM/WB.
    assign stall = ~rst & ((~busy & access) | (busy & ~dmem_ack & ~abort));

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            dmem_req      <= 1'b0;
            dmem_we       <= 1'b0;
            dmem_addr     <= '0;
            dmem_wdata    <= '0;
            wb_reg_write  <= 1'b0;
            wb_mem_to_reg <= 1'b0;
            wb_rd         <= '0;
            wb_read_data  <= '0;
            wb_alu_result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (access) begin
                        // Store has priority: dmem_we follows mem_write_reg.
                        state         <= BUSY;
                        dmem_req      <= 1'b1;
                        dmem_we       <= mem_write_reg;
                        dmem_addr     <= alu_result_reg;
                        dmem_wdata    <= write_data_reg;
                        wb_reg_write  <= 1'b0;
                        wb_mem_to_reg <= 1'b0;
                    end else begin
                        wb_reg_write  <= reg_write_reg;
                        wb_mem_to_reg <= 1'b0;
                        wb_rd         <= rd_reg;
                        wb_alu_result <= alu_result_reg;
                    end
                end
                BUSY: begin
                    if (dmem_ack) begin
                        state         <= IDLE;
                        dmem_req      <= 1'b0;
                        wb_reg_write  <= reg_write_reg & ~dmem_we;
                        wb_mem_to_reg <= ~dmem_we;
                        wb_rd         <= rd_reg;
                        wb_alu_result <= alu_result_reg;
                        if (!dmem_we)
                            wb_read_data <= dmem_rdata;
                    end else begin
                        if (abort) begin
                            state    <= IDLE;
                            dmem_req <= 1'b0;
                        end
                        wb_reg_write  <= 1'b0;
                        wb_mem_to_reg <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_stage_ctrl
//
// Directed bench for mem_stage_ctrl. Inputs change 1 time unit after a rising
// edge; combinational stall is observed 1 unit after that, registered outputs
// 1 unit after the following edge. The memory side is driven directly by the
// bench (ack and rdata per vector).
// -----------------------------------------------------------------------------
module tb_mem_stage_ctrl;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              mem_write_reg;
    logic              mem_read_reg;
    logic              reg_write_reg;
    logic [ADDR_W-1:0] alu_result_reg;
    logic [DATA_W-1:0] write_data_reg;
    logic [REG_W-1:0]  rd_reg;
    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic [DATA_W-1:0] dmem_rdata;
    logic              dmem_ack;
    logic              stall;
    logic              wb_reg_write;
    logic              wb_mem_to_reg;
    logic [REG_W-1:0]  wb_rd;
    logic [DATA_W-1:0] wb_read_data;
    logic [ADDR_W-1:0] wb_alu_result;
    logic              mem_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_stage_ctrl #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .REG_W  (REG_W),
        .TIMEOUT(4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_write_reg (mem_write_reg),
        .mem_read_reg  (mem_read_reg),
        .reg_write_reg (reg_write_reg),
        .alu_result_reg(alu_result_reg),
        .write_data_reg(write_data_reg),
        .rd_reg        (rd_reg),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_addr     (dmem_addr),
        .dmem_wdata    (dmem_wdata),
        .dmem_rdata    (dmem_rdata),
        .dmem_ack      (dmem_ack),
        .stall         (stall),
        .wb_reg_write  (wb_reg_write),
        .wb_mem_to_reg (wb_mem_to_reg),
        .wb_rd         (wb_rd),
        .wb_read_data  (wb_read_data),
        .wb_alu_result (wb_alu_result),
        .mem_err       (mem_err)
    );

    // Advance to 1 unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic wr, input logic rdn, input logic rw,
                          input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] wdat,
                          input logic [REG_W-1:0] rd);
        mem_write_reg  = wr;
        mem_read_reg   = rdn;
        reg_write_reg  = rw;
        alu_result_reg = addr;
        write_data_reg = wdat;
        rd_reg         = rd;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        dmem_ack   = 1'b0;
        dmem_rdata = '0;
        set_op(1'b0, 1'b1, 1'b1, 32'h20, 32'h55, 5'd9);
        tick();
        tick();
        total++;
        if (stall !== 1'b0) begin
            bad++; $display("FAIL reset_stall got=%b want=0", stall);
        end
        total++;
        if (dmem_req !== 1'b0 || dmem_we !== 1'b0 || dmem_addr !== '0 || dmem_wdata !== '0) begin
            bad++; $display("FAIL reset_dmem got req=%b we=%b addr=%h wdata=%h want all 0",
                            dmem_req, dmem_we, dmem_addr, dmem_wdata);
        end
        total++;
        if ({wb_reg_write, wb_mem_to_reg, wb_rd, wb_read_data, wb_alu_result, mem_err} !== '0) begin
            bad++; $display("FAIL reset_wb got rw=%b m2r=%b rd=%0d rdata=%h alu=%h err=%b want all 0",
                            wb_reg_write, wb_mem_to_reg, wb_rd, wb_read_data, wb_alu_result, mem_err);
        end
        rst = 1'b0;
    endtask

    task automatic test_alu_op();
        set_op(1'b0, 1'b0, 1'b1, 32'h10, 32'h0, 5'd3);
        #1;
        total++;
        if (stall !== 1'b0) begin
            bad++; $display("FAIL alu_stall got=%b want=0", stall);
        end
        tick();
        total++;
        if (wb_reg_write !== 1'b1 || wb_rd !== 5'd3 || wb_alu_result !== 32'h10 ||
            wb_mem_to_reg !== 1'b0 || dmem_req !== 1'b0) begin
            bad++; $display("FAIL alu_wb got rw=%b rd=%0d alu=%h m2r=%b req=%b want 1/3/10/0/0",
                            wb_reg_write, wb_rd, wb_alu_result, wb_mem_to_reg, dmem_req);
        end
    endtask

    // Store: ack arrives in the 4th BUSY cycle -> stall high for the IDLE
    // detect cycle plus 3 BUSY cycles.
    task automatic test_store_slow();
        int stall_cnt = 0;
        set_op(1'b1, 1'b0, 1'b1, 32'h40, 32'h1234, 5'd7);
        #1;
        if (stall === 1'b1) stall_cnt++;
        tick();
        for (int c = 0; c < 3; c++) begin
            total++;
            if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== 32'h40 ||
                dmem_wdata !== 32'h1234 || wb_reg_write !== 1'b0) begin
                bad++; $display("FAIL store_hold c=%0d got req=%b we=%b addr=%h wdata=%h rw=%b want 1/1/40/1234/0",
                                c, dmem_req, dmem_we, dmem_addr, dmem_wdata, wb_reg_write);
            end
            #1;
            if (stall === 1'b1) stall_cnt++;
            tick();
        end
        dmem_ack = 1'b1;
        #1;
        if (stall === 1'b1) stall_cnt++;
        total++;
        if (stall_cnt !== 4) begin
            bad++; $display("FAIL store_stall_cycles got=%0d want=4", stall_cnt);
        end
        tick();
        dmem_ack = 1'b0;
        set_op(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        total++;
        if (dmem_req !== 1'b0 || wb_reg_write !== 1'b0 || wb_mem_to_reg !== 1'b0 ||
            wb_rd !== 5'd7 || wb_alu_result !== 32'h40 || wb_read_data !== 32'h0) begin
            bad++; $display("FAIL store_retire got req=%b rw=%b m2r=%b rd=%0d alu=%h rdata=%h want 0/0/0/7/40/0",
                            dmem_req, wb_reg_write, wb_mem_to_reg, wb_rd, wb_alu_result, wb_read_data);
        end
    endtask

    task automatic test_back_to_back();
        // First load: ack in the first BUSY cycle.
        set_op(1'b0, 1'b1, 1'b1, 32'h8, 32'h0, 5'd5);
        #1;
        total++;
        if (stall !== 1'b1) begin
            bad++; $display("FAIL load1_idle_stall got=%b want=1", stall);
        end
        tick();
        total++;
        if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== 32'h8) begin
            bad++; $display("FAIL load1_req got req=%b we=%b addr=%h want 1/0/8", dmem_req, dmem_we, dmem_addr);
        end
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hDEADBEEF;
        #1;
        total++;
        if (stall !== 1'b0) begin
            bad++; $display("FAIL load1_ack_stall got=%b want=0", stall);
        end
        tick();
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        total++;
        if (wb_read_data !== 32'hDEADBEEF || wb_mem_to_reg !== 1'b1 || wb_rd !== 5'd5 ||
            wb_reg_write !== 1'b1 || dmem_req !== 1'b0) begin
            bad++; $display("FAIL load1_wb got rdata=%h m2r=%b rd=%0d rw=%b req=%b want deadbeef/1/5/1/0",
                            wb_read_data, wb_mem_to_reg, wb_rd, wb_reg_write, dmem_req);
        end
        // Second load enters right away.
        set_op(1'b0, 1'b1, 1'b1, 32'hC, 32'h0, 5'd6);
        #1;
        total++;
        if (stall !== 1'b1) begin
            bad++; $display("FAIL load2_idle_stall got=%b want=1", stall);
        end
        tick();
        total++;
        if (wb_reg_write !== 1'b0 || dmem_req !== 1'b1 || dmem_addr !== 32'hC) begin
            bad++; $display("FAIL load2_no_dup got rw=%b req=%b addr=%h want 0/1/c", wb_reg_write, dmem_req, dmem_addr);
        end
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hCAFEF00D;
        tick();
        dmem_ack   = 1'b0;
        set_op(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        total++;
        if (wb_read_data !== 32'hCAFEF00D || wb_mem_to_reg !== 1'b1 || wb_rd !== 5'd6 || wb_reg_write !== 1'b1) begin
            bad++; $display("FAIL load2_wb got rdata=%h m2r=%b rd=%0d rw=%b want cafef00d/1/6/1",
                            wb_read_data, wb_mem_to_reg, wb_rd, wb_reg_write);
        end
        tick();
        total++;
        if (wb_reg_write !== 1'b0 || wb_read_data !== 32'hCAFEF00D) begin
            bad++; $display("FAIL after_load_idle got rw=%b rdata=%h want 0/cafef00d", wb_reg_write, wb_read_data);
        end
    endtask

    task automatic test_reset_mid_access();
        set_op(1'b0, 1'b1, 1'b1, 32'h30, 32'h0, 5'd4);
        tick();   // now BUSY cycle 1
        tick();   // now BUSY cycle 2
        rst = 1'b1;
        #1;
        total++;
        if (stall !== 1'b0) begin
            bad++; $display("FAIL midrst_stall got=%b want=0", stall);
        end
        tick();
        rst = 1'b0;
        set_op(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        total++;
        if (dmem_req !== 1'b0 || wb_reg_write !== 1'b0 || wb_read_data !== 32'h0) begin
            bad++; $display("FAIL midrst_drop got req=%b rw=%b rdata=%h want 0/0/0", dmem_req, wb_reg_write, wb_read_data);
        end
        // Late ack in IDLE must be ignored.
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h12345678;
        tick();
        dmem_ack   = 1'b0;
        tick();
        total++;
        if (dmem_req !== 1'b0 || wb_read_data !== 32'h0 || wb_mem_to_reg !== 1'b0 || stall !== 1'b0) begin
            bad++; $display("FAIL idle_ack_ignored got req=%b rdata=%h m2r=%b stall=%b want 0/0/0/0",
                            dmem_req, wb_read_data, wb_mem_to_reg, stall);
        end
    endtask

    task automatic test_timeout();
        set_op(1'b0, 1'b1, 1'b1, 32'h50, 32'h0, 5'd2);
        tick();   // BUSY cycle 1
`ifdef MEM_TIMEOUT_EN
        for (int c = 0; c < 3; c++) begin
            total++;
            if (stall !== 1'b1) begin
                bad++; $display("FAIL timeout_stall c=%0d got=%b want=1", c, stall);
            end
            tick();
        end
        total++;
        if (stall !== 1'b0) begin
            bad++; $display("FAIL timeout_abort_stall got=%b want=0", stall);
        end
        tick();
        set_op(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        total++;
        if (dmem_req !== 1'b0 || mem_err !== 1'b1 || wb_reg_write !== 1'b0) begin
            bad++; $display("FAIL timeout_abort got req=%b err=%b rw=%b want 0/1/0", dmem_req, mem_err, wb_reg_write);
        end
        tick();
        tick();
        total++;
        if (mem_err !== 1'b1) begin
            bad++; $display("FAIL timeout_sticky got=%b want=1", mem_err);
        end
`else
        for (int c = 0; c < 8; c++) begin
            total++;
            if (stall !== 1'b1 || dmem_req !== 1'b1) begin
                bad++; $display("FAIL noto_wait c=%0d got stall=%b req=%b want 1/1", c, stall, dmem_req);
            end
            tick();
        end
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hA5A5A5A5;
        tick();
        dmem_ack   = 1'b0;
        set_op(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        total++;
        if (dmem_req !== 1'b0 || wb_read_data !== 32'hA5A5A5A5 || wb_rd !== 5'd2 || mem_err !== 1'b0) begin
            bad++; $display("FAIL noto_ack got req=%b rdata=%h rd=%0d err=%b want 0/a5a5a5a5/2/0",
                            dmem_req, wb_read_data, wb_rd, mem_err);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_alu_op();
        test_store_slow();
        test_back_to_back();
        test_reset_mid_access();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
